// File: rtl/aq_djpeg_feeder.sv
// aq_djpeg_feeder: fetches a word stream from memory through a prefetch FIFO into the JPEG decoder input.
// Optional EOI padding after the last word: define AQ_DJPEG_FEEDER_EOI_PAD_EN.
module aq_djpeg_feeder #(
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       DataIn,
  output logic              DataInEnable,
  input  logic              DataInRead,
  input  logic              JpegDecodeIdle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0]  OCC_ZERO  = OCC_W'(0);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W+1)'(0);
  localparam logic [OCC_W:0]    DEPTH_SUM = (OCC_W+1)'(FIFO_DEPTH);
  localparam logic [31:0]       PAD_WORD  = 32'hFFD9FFD9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W:0]    r_word_count;
  logic [ADDR_W:0]    r_req_cnt;
  logic [ADDR_W:0]    r_pop_cnt;
  logic [OCC_W-1:0]   r_outstanding;
  logic [OCC_W-1:0]   r_fifo_cnt;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic               r_done;
  logic               r_underrun;

  logic               w_start_acc;
  logic               w_grant;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic               w_last_pop;
  logic               w_mem_req;
  logic               w_data_en;
  logic [31:0]        w_data;
  logic               w_underrun_set;
  logic [OCC_W:0]     w_credit_sum;

  assign w_start_acc  = start && (r_state == S_IDLE);
  assign w_fifo_empty = (r_fifo_cnt == OCC_ZERO);
  assign w_grant      = w_mem_req && mem_gnt;
  // Responses with nothing outstanding are stale (e.g. issued before a reset) and dropped.
  assign w_push       = mem_rvalid && (r_outstanding != OCC_ZERO);
  assign w_pop        = DataInRead && !w_fifo_empty;
  assign w_last_pop   = w_pop && ((r_pop_cnt + CNT_ONE) == r_word_count);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (word_count == CNT_ZERO) ? S_WAIT : S_STREAM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (w_last_pop || (r_pop_cnt == r_word_count)) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      S_WAIT: begin
        if (JpegDecodeIdle) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: memory credit, decoder head word, underrun detection
  always_comb begin
    w_mem_req      = 1'b0;
    w_underrun_set = 1'b0;
    w_credit_sum   = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
    w_data_en      = !w_fifo_empty;
    w_data         = w_fifo_empty ? 32'h0000_0000 : r_mem[r_rptr];
    case (r_state)
      S_STREAM: begin
        w_mem_req      = (r_req_cnt < r_word_count) && (w_credit_sum < DEPTH_SUM);
        w_underrun_set = DataInRead && w_fifo_empty;
      end
      S_WAIT: begin
`ifdef AQ_DJPEG_FEEDER_EOI_PAD_EN
        w_data_en = 1'b1;
        w_data    = w_fifo_empty ? PAD_WORD : r_mem[r_rptr];
`else
        w_underrun_set = DataInRead && w_fifo_empty;
`endif
      end
      default: begin
        w_mem_req      = 1'b0;
        w_underrun_set = 1'b0;
      end
    endcase
  end

  // Transfer parameters and progress counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base       <= {ADDR_W{1'b0}};
      r_word_count <= CNT_ZERO;
      r_req_cnt    <= CNT_ZERO;
      r_pop_cnt    <= CNT_ZERO;
    end else if (w_start_acc) begin
      r_base       <= base_addr;
      r_word_count <= word_count;
      r_req_cnt    <= CNT_ZERO;
      r_pop_cnt    <= CNT_ZERO;
    end else begin
      if (w_grant) begin
        r_req_cnt <= r_req_cnt + CNT_ONE;
      end
      if (w_pop) begin
        r_pop_cnt <= r_pop_cnt + CNT_ONE;
      end
    end
  end

  // Outstanding-read credit and FIFO occupancy/pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= OCC_ZERO;
      r_fifo_cnt    <= OCC_ZERO;
      r_wptr        <= {PTR_W{1'b0}};
      r_rptr        <= {PTR_W{1'b0}};
    end else begin
      case ({w_grant, w_push})
        2'b10:   r_outstanding <= r_outstanding + OCC_ONE;
        2'b01:   r_outstanding <= r_outstanding - OCC_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + OCC_ONE;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - OCC_ONE;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are only visible while occupancy is non-zero
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= mem_rdata;
    end
  end

  // Completion pulse and sticky underrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done <= (r_state == S_WAIT) && JpegDecodeIdle;
      if (w_start_acc) begin
        r_underrun <= 1'b0;
      end else if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign underrun     = r_underrun;
  assign mem_req      = w_mem_req;
  assign mem_addr     = r_base + r_req_cnt[ADDR_W-1:0];
  assign DataIn       = w_data;
  assign DataInEnable = w_data_en;

endmodule

// File: tb/tb_aq_djpeg_feeder.sv
// Testbench for aq_djpeg_feeder: randomized memory/decoder models checked against a stream-level reference.
module tb_aq_djpeg_feeder;
  localparam int AW    = 20;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, underrun, mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = 32'h0;
  logic [31:0]   DataIn;
  logic          DataInEnable;
  logic          DataInRead;
  logic          JpegDecodeIdle = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  aq_djpeg_feeder #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .underrun(underrun), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .DataIn(DataIn), .DataInEnable(DataInEnable), .DataInRead(DataInRead),
    .JpegDecodeIdle(JpegDecodeIdle)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed hash of the word address
  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {{(32-AW){1'b0}}, a};
    return (x * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  // Memory and decoder behaviour knobs
  int gnt_pct = 100, rv_pct = 100, lat_min = 2, lat_max = 2, rd_pct = 0;
  logic rd_rand = 1'b0, rd_manual = 1'b0, rd_manual_val = 1'b0;
  assign DataInRead = rd_manual ? rd_manual_val : (rd_rand && DataInEnable);

  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t rq[$];
  int cyc = 0, last_due = 0;

  // Reference-side logs and stream-level counters
  logic [AW-1:0] req_log[$];
  logic [31:0]   out_log[$];
  int done_cnt = 0, pad_cnt = 0, pad_bad = 0;
  int g = 0, r = 0, p = 0, maxbuf = 0;

  always @(negedge clk) begin
    mem_gnt = ($urandom_range(99) < gnt_pct);
    if (rq.size() > 0 && rq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].data;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    rd_rand = ($urandom_range(99) < rd_pct);
  end

  always @(posedge clk) begin
    if (rst) begin
      g = 0; r = 0; p = 0;
    end else begin
      if (start && !busy) begin
        g = 0; r = 0; p = 0; maxbuf = 0;
      end
      if (DataInRead && DataInEnable) begin
        if (r > p) begin
          out_log.push_back(DataIn);
          p++;
        end else begin
          pad_cnt++;
          if (DataIn !== 32'hFFD9FFD9) pad_bad++;
        end
      end
      if (mem_req && mem_gnt) begin
        int d;
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d < last_due) d = last_due;
        last_due = d;
        rq.push_back('{due: d, data: word_of(mem_addr)});
        req_log.push_back(mem_addr);
        g++;
      end
      if (mem_rvalid && g > r) r++;
      if (done) done_cnt++;
      if (g - p > maxbuf) maxbuf = g - p;
    end
    if (mem_rvalid) rq.delete(0);
    cyc++;
  end

  function automatic int first_word_err(input logic [AW-1:0] b, input int n, input int o0);
    if (out_log.size() != o0 + n) return -2;
    for (int i = 0; i < n; i++) if (out_log[o0+i] !== word_of(b + AW'(i))) return i;
    return -1;
  endfunction

  function automatic int first_addr_err(input logic [AW-1:0] b, input int n, input int a0);
    if (req_log.size() != a0 + n) return -2;
    for (int i = 0; i < n; i++) if (req_log[a0+i] !== b + AW'(i)) return i;
    return -1;
  endfunction

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    @(negedge clk);
    base_addr = b; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (out_log.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && rq.size() > 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, underrun, mem_req, DataInEnable} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 00000", {busy, done, underrun, mem_req, DataInEnable});
    end
    tests_run++;
    if (mem_addr !== '0 || DataIn !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: mem_addr %h DataIn %h, required 0 and 0", mem_addr, DataIn);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int o0, a0, d0, e; bit ok;
    gnt_pct = 100; rv_pct = 100; lat_min = 2; lat_max = 2; rd_pct = 100; JpegDecodeIdle = 1'b0;
    drain();
    o0 = out_log.size(); a0 = req_log.size(); d0 = done_cnt;
    do_start(20'h00100, 21'd8);
    tests_run++;
    if (!(mem_req === 1'b1 && busy === 1'b1 && mem_addr === 20'h00100)) begin
      tests_failed++;
      $display("FAIL basic_req_latency: req %b busy %b addr %h, required 1 1 00100", mem_req, busy, mem_addr);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (DataInEnable !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_early_enable: got %b, required 0", DataInEnable);
    end
    @(negedge clk);
    tests_run++;
    if (DataInEnable !== 1'b1 || DataIn !== word_of(20'h00100)) begin
      tests_failed++;
      $display("FAIL basic_first_word: en %b data %h, required 1 %h", DataInEnable, DataIn, word_of(20'h00100));
    end
    wait_out(o0 + 8, 100, ok);
    rd_pct = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || done_cnt != d0) begin
      tests_failed++;
      $display("FAIL basic_wait_idle: busy %b dones %0d, required 1 0", busy, done_cnt - d0);
    end
    JpegDecodeIdle = 1'b1;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: got %b, required 1", done);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_after_done: done %b busy %b, required 0 0", done, busy);
    end
    e = first_word_err(20'h00100, 8, o0);
    tests_run++;
    if (e !== -1) begin
      tests_failed++;
      $display("FAIL basic_words: bad index %0d (count %0d), required -1 (count 8)", e, out_log.size() - o0);
    end
    e = first_addr_err(20'h00100, 8, a0);
    tests_run++;
    if (e !== -1) begin
      tests_failed++;
      $display("FAIL basic_addrs: bad index %0d (count %0d), required -1 (count 8)", e, req_log.size() - a0);
    end
    tests_run++;
    if (done_cnt - d0 != 1 || underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_status: dones %0d underrun %b, required 1 0", done_cnt - d0, underrun);
    end
  endtask

  task automatic test_backpressure();
    int o0, a0, e; bit ok;
    gnt_pct = 100; rv_pct = 100; lat_min = 2; lat_max = 2; rd_pct = 0; JpegDecodeIdle = 1'b1;
    drain();
    o0 = out_log.size(); a0 = req_log.size();
    do_start(20'h02000, 21'd12);
    repeat (20) @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0 || (r - p) != DEPTH || (g - r) != 0) begin
      tests_failed++;
      $display("FAIL bp_credit: req %b buffered %0d outstanding %0d, required 0 %0d 0", mem_req, r - p, g - r, DEPTH);
    end
    tests_run++;
    if (DataInEnable !== 1'b1 || DataIn !== word_of(20'h02000)) begin
      tests_failed++;
      $display("FAIL bp_head: en %b data %h, required 1 %h", DataInEnable, DataIn, word_of(20'h02000));
    end
    rd_pct = 100;
    wait_done(200, ok);
    rd_pct = 0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_timeout: done %b, required 1", ok); end
    e = first_word_err(20'h02000, 12, o0);
    tests_run++;
    if (e !== -1) begin
      tests_failed++;
      $display("FAIL bp_words: bad index %0d (count %0d), required -1 (count 12)", e, out_log.size() - o0);
    end
    e = first_addr_err(20'h02000, 12, a0);
    tests_run++;
    if (e !== -1) begin
      tests_failed++;
      $display("FAIL bp_addrs: bad index %0d, required -1", e);
    end
  endtask

  task automatic test_concurrent();
    int o0, a0, d0, e, n; bit ok; logic [AW-1:0] b;
    for (int run = 0; run < 2; run++) begin
      gnt_pct = 60; rv_pct = 60; lat_min = 1; lat_max = 4; rd_pct = 50; JpegDecodeIdle = 1'b1;
      drain();
      b = (run == 0) ? AW'($urandom) : 20'hFFFFA;
      n = (run == 0) ? 64 : 16;
      o0 = out_log.size(); a0 = req_log.size(); d0 = done_cnt;
      do_start(b, (AW+1)'(n));
      wait_done(3000, ok);
      rd_pct = 0;
      @(negedge clk);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL conc_timeout run %0d: done %b, required 1", run, ok); end
      e = first_word_err(b, n, o0);
      tests_run++;
      if (e !== -1) begin
        tests_failed++;
        $display("FAIL conc_words run %0d: bad index %0d (count %0d), required -1 (count %0d)", run, e, out_log.size() - o0, n);
      end
      e = first_addr_err(b, n, a0);
      tests_run++;
      if (e !== -1) begin
        tests_failed++;
        $display("FAIL conc_addrs run %0d: bad index %0d, required -1", run, e);
      end
      tests_run++;
      if (maxbuf > DEPTH || underrun !== 1'b0 || done_cnt - d0 != 1) begin
        tests_failed++;
        $display("FAIL conc_status run %0d: occupancy %0d underrun %b dones %0d, required <=%0d 0 1", run, maxbuf, underrun, done_cnt - d0, DEPTH);
      end
    end
  endtask

  task automatic test_back_to_back();
    int o0, s, el, e; bit ok;
    gnt_pct = 100; rv_pct = 100; lat_min = 1; lat_max = 1; rd_pct = 100; JpegDecodeIdle = 1'b1;
    drain();
    o0 = out_log.size();
    do_start(20'h03000, 21'd16);
    s = cyc - 1;
    wait_done(200, ok);
    el = cyc - s;
    rd_pct = 0;
    tests_run++;
    if (!ok || el > 16 + 5 || el < 16 + 1) begin
      tests_failed++;
      $display("FAIL b2b_throughput: done %b after %0d cycles, required 1 within 17..21", ok, el);
    end
    e = first_word_err(20'h03000, 16, o0);
    tests_run++;
    if (e !== -1) begin
      tests_failed++;
      $display("FAIL b2b_words: bad index %0d, required -1", e);
    end
  endtask

  task automatic test_empty();
    int a0, d0, bad; bit ok;
    rd_pct = 0; JpegDecodeIdle = 1'b1;
    drain();
    a0 = req_log.size(); d0 = done_cnt;
    do_start(20'h00040, 21'd0);
    tests_run++;
    if (busy !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_wait: busy %b req %b done %b, required 1 0 0", busy, mem_req, done);
    end
    base_addr = 20'h00050; word_count = 21'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_done: done %b busy %b, required 1 0", done, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_ignored_start: done %b busy %b req %b, required 0 0 0", done, busy, mem_req);
    end
    JpegDecodeIdle = 1'b0;
    do_start(20'h00060, 21'd0);
    @(negedge clk);
    base_addr = 20'h00070; word_count = 21'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b1 || mem_req !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL empty_busy_start: %0d bad cycles, required 0", bad);
    end
    JpegDecodeIdle = 1'b1;
    wait_done(10, ok);
    @(negedge clk);
    tests_run++;
    if (!ok || done_cnt - d0 != 2 || req_log.size() != a0) begin
      tests_failed++;
      $display("FAIL empty_totals: done %b dones %0d reqs %0d, required 1 2 0", ok, done_cnt - d0, req_log.size() - a0);
    end
  endtask

  task automatic test_underrun();
    int o0, e, pc; bit ok;
    gnt_pct = 100; rv_pct = 100; lat_min = 5; lat_max = 5; rd_pct = 0; JpegDecodeIdle = 1'b0;
    drain();
    o0 = out_log.size();
    do_start(20'h00300, 21'd4);
    rd_manual = 1'b1; rd_manual_val = 1'b1;
    @(negedge clk);
    rd_manual = 1'b0; rd_manual_val = 1'b0;
    tests_run++;
    if (underrun !== 1'b1 || out_log.size() != o0) begin
      tests_failed++;
      $display("FAIL underrun_set: underrun %b pops %0d, required 1 0", underrun, out_log.size() - o0);
    end
    rd_pct = 100;
    wait_out(o0 + 4, 100, ok);
    rd_pct = 0;
    e = first_word_err(20'h00300, 4, o0);
    tests_run++;
    if (underrun !== 1'b1 || e !== -1) begin
      tests_failed++;
      $display("FAIL underrun_sticky: underrun %b word err %0d, required 1 -1", underrun, e);
    end
    JpegDecodeIdle = 1'b1;
    wait_done(20, ok);
    JpegDecodeIdle = 1'b0;
    drain();
    o0 = out_log.size();
    do_start(20'h00400, 21'd2);
    tests_run++;
    if (underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL underrun_clear: got %b, required 0", underrun);
    end
    rd_pct = 100;
    wait_out(o0 + 2, 100, ok);
    rd_pct = 0;
    @(negedge clk);
    pc = pad_cnt;
`ifdef AQ_DJPEG_FEEDER_EOI_PAD_EN
    tests_run++;
    if (DataInEnable !== 1'b1 || DataIn !== 32'hFFD9FFD9) begin
      tests_failed++;
      $display("FAIL pad_word: en %b data %h, required 1 ffd9ffd9", DataInEnable, DataIn);
    end
`else
    tests_run++;
    if (DataInEnable !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_enable: got %b, required 0", DataInEnable);
    end
`endif
    rd_manual = 1'b1; rd_manual_val = 1'b1;
    @(negedge clk);
    rd_manual = 1'b0; rd_manual_val = 1'b0;
`ifdef AQ_DJPEG_FEEDER_EOI_PAD_EN
    tests_run++;
    if (underrun !== 1'b0 || busy !== 1'b1 || pad_cnt - pc != 1 || pad_bad != 0 || out_log.size() != o0 + 2) begin
      tests_failed++;
      $display("FAIL pad_read: underrun %b busy %b pads %0d bad %0d, required 0 1 1 0", underrun, busy, pad_cnt - pc, pad_bad);
    end
`else
    tests_run++;
    if (underrun !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_underrun: underrun %b busy %b, required 1 1", underrun, busy);
    end
`endif
    JpegDecodeIdle = 1'b1;
    wait_done(20, ok);
  endtask

  task automatic test_reset_mid();
    int o0, bad; bit ok;
    gnt_pct = 100; rv_pct = 100; lat_min = 6; lat_max = 6; rd_pct = 100; JpegDecodeIdle = 1'b0;
    drain();
    o0 = out_log.size();
    do_start(20'h00500, 21'd8);
    wait_out(o0 + 3, 100, ok);
    rd_pct = 0;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, underrun, mem_req, DataInEnable} !== 5'b0 || mem_addr !== '0 || DataIn !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: flags %b addr %h data %h, required 00000 0 0", {busy, done, underrun, mem_req, DataInEnable}, mem_addr, DataIn);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (DataInEnable !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (!ok || bad != 0) begin
      tests_failed++;
      $display("FAIL midreset_late_rvalid: reached3 %b bad cycles %0d, required 1 0", ok, bad);
    end
    JpegDecodeIdle = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_concurrent();
    test_back_to_back();
    test_empty();
    test_underrun();
    test_reset_mid();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
